// File: rtl/display_capture_pkg.sv
// Shared definitions for the display capture block: default geometry, state
// encodings and the matrix bit-index rule used across the display pipeline.
package display_capture_pkg;

   localparam int GS  = 8;
   localparam int STB = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SYNC   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_NEXT   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      SYNC   = ST_SYNC,
      SETTLE = ST_SETTLE,
      NEXT   = ST_NEXT,
      DONE   = ST_DONE
   } cap_state_t;

   // Matrix bit for column c of row r in a g x g grid.
   function automatic int bit_idx(input int r, input int c, input int g);
      return r * g + c;
   endfunction

endpackage

// File: rtl/display_capture_onehot_dec.sv
// Classifies a row-select vector as blank, one-hot or illegal and returns the
// index of the set bit (highest set bit when illegal).
module onehot_dec #(
   parameter int W  = 8,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          is_blank,
   output logic          is_onehot,
   output logic          is_illegal
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) idx = IW'(i);
      end
   end

   assign is_blank   = (vec == '0);
   assign is_onehot  = !is_blank && ((vec & (vec - W'(1))) == '0);
   assign is_illegal = !is_blank && !is_onehot;

endmodule

// File: rtl/display_capture.sv
// Rebuilds the gs x gs frame from the scanner's row/column lines and publishes
// it atomically once per completed frame.
//
// state  | meaning
// IDLE   | disabled, waiting for e_cap_i
// SYNC   | hunting for row 0 to align to the frame
// SETTLE | counting stable column samples for exp_row
// NEXT   | row stored, waiting for exp_row+1 (or finishing after the last row)
// DONE   | frame published on matrix_o, d_cap_o high until e_cap_i drops
module display_capture
   import display_capture_pkg::*;
#(
   parameter int gs  = GS,
   parameter int stb = STB
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             e_cap_i,
   input  logic [gs-1:0]    row_val_i,
   input  logic [gs-1:0]    col_val_i,
   output logic [gs*gs-1:0] matrix_o,
   output logic             d_cap_o,
   output logic             err_o
);

   localparam int IW = $clog2(gs);

   cap_state_t        state;
   logic [gs-1:0]     row_q;
   logic [gs-1:0]     col_q;
   logic [IW-1:0]     exp_row;
   logic [gs-1:0]     ref_col;
   logic [3:0]        cnt;
   logic [gs*gs-1:0]  frame_q;

   logic [IW-1:0]     row_idx;
   logic              is_blank;
   logic              is_onehot;
   logic              is_illegal;
   logic              is_exp;
   logic              is_nxt;

   onehot_dec #(.W(gs), .IW(IW)) u_dec (
      .vec        (row_q),
      .idx        (row_idx),
      .is_blank   (is_blank),
      .is_onehot  (is_onehot),
      .is_illegal (is_illegal)
   );

   assign is_exp = is_onehot && (row_idx == exp_row);
   assign is_nxt = is_onehot && (row_idx == exp_row + IW'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         exp_row  <= '0;
         ref_col  <= '0;
         cnt      <= '0;
         frame_q  <= '0;
         matrix_o <= '0;
         d_cap_o  <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         row_q <= row_val_i;
         col_q <= col_val_i;
         case (state)
            IDLE: begin
               d_cap_o <= 1'b0;
               if (e_cap_i) begin
                  err_o <= 1'b0;
                  state <= SYNC;
               end
            end
            SYNC: begin
               if (!e_cap_i) begin
                  state <= IDLE;
               end else if (is_onehot && row_idx == '0) begin
                  exp_row <= '0;
                  ref_col <= col_q;
                  cnt     <= 4'd1;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               // Abort is checked first so a dropping enable suppresses the write.
               if (!e_cap_i) begin
                  state <= IDLE;
               end else if (cnt == 4'(stb)) begin
                  frame_q[bit_idx(int'(exp_row), 0, gs) +: gs] <= ref_col;
                  state <= NEXT;
               end else if (is_exp) begin
                  if (col_q == ref_col) begin
                     cnt <= cnt + 4'd1;
                  end else begin
                     ref_col <= col_q;
                     cnt     <= 4'd1;
                  end
               end else if (is_illegal || is_onehot) begin
                  err_o <= 1'b1;
                  state <= SYNC;
               end
            end
            NEXT: begin
               if (!e_cap_i) begin
                  state <= IDLE;
               end else if (exp_row == IW'(gs - 1)) begin
                  matrix_o <= frame_q;
                  d_cap_o  <= 1'b1;
                  state    <= DONE;
               end else if (is_nxt) begin
                  exp_row <= exp_row + IW'(1);
                  ref_col <= col_q;
                  cnt     <= 4'd1;
                  state   <= SETTLE;
               end else if (!is_blank && !is_exp) begin
                  err_o <= 1'b1;
                  state <= SYNC;
               end
            end
            DONE: begin
               if (!e_cap_i) begin
                  d_cap_o <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture with gs=8, stb=2.
module tb_display_capture;

   localparam logic [63:0] DIAG  = 64'h8040201008040201;
   localparam logic [63:0] ONES  = 64'hFFFFFFFFFFFFFFFF;
   localparam logic [63:0] PAT_A5 = 64'hA5A5A5A5A5A5A5A5;
   localparam logic [63:0] PAT_IDX = 64'h0706050403020100;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        e_cap_i = 1'b0;
   logic [7:0]  row_val_i = 8'h00;
   logic [7:0]  col_val_i = 8'h00;
   logic [63:0] matrix_o;
   logic        d_cap_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   display_capture #(.gs(8), .stb(2)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .e_cap_i   (e_cap_i),
      .row_val_i (row_val_i),
      .col_val_i (col_val_i),
      .matrix_o  (matrix_o),
      .d_cap_o   (d_cap_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step(input logic [7:0] r, input logic [7:0] c);
      @(posedge clk_i);
      #1;
      row_val_i = r;
      col_val_i = c;
   endtask

   task automatic scan_row(input int r, input logic [7:0] c, input int hold, input int blanks);
      logic [7:0] rv;
      rv = 8'h01 << r;
      for (int i = 0; i < hold; i++) step(rv, c);
      for (int i = 0; i < blanks; i++) step(8'h00, 8'h00);
   endtask

   task automatic wait_done(output bit seen);
      seen = d_cap_o;
      for (int i = 0; i < 100 && !seen; i++) begin
         step(8'h00, 8'h00);
         seen = d_cap_o;
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         row_val_i = 8'($urandom);
         col_val_i = 8'($urandom);
         e_cap_i   = 1'($urandom);
      end
      checks++; if (matrix_o !== 64'h0) begin errors++; $display("FAIL reset_matrix got=%h want=%h", matrix_o, 64'h0); end
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", d_cap_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err_o); end
      @(negedge clk_i);
      e_cap_i = 1'b0;
      row_val_i = 8'h00;
      col_val_i = 8'h00;
      rst_i = 1'b0;
      for (int r = 0; r < 8; r++) scan_row(r, 8'hFF, 1, 0);
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL idle_done got=%b want=0", d_cap_o); end
      checks++; if (matrix_o !== 64'h0) begin errors++; $display("FAIL idle_matrix got=%h want=%h", matrix_o, 64'h0); end
   endtask

   task automatic test_clean_frame;
      logic [7:0] v;
      step(8'h01, 8'h01);
      e_cap_i = 1'b1;
      for (int k = 1; k < 24; k++) begin
         v = 8'h01 << (k / 3);
         step(v, v);
      end
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL clean_early_done got=%b want=0", d_cap_o); end
      checks++; if (matrix_o !== 64'h0) begin errors++; $display("FAIL clean_early_matrix got=%h want=%h", matrix_o, 64'h0); end
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b1) begin errors++; $display("FAIL clean_done got=%b want=1", d_cap_o); end
      checks++; if (matrix_o !== DIAG) begin errors++; $display("FAIL clean_matrix got=%h want=%h", matrix_o, DIAG); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clean_err got=%b want=0", err_o); end
      e_cap_i = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL clean_done_drop got=%b want=0", d_cap_o); end
      checks++; if (matrix_o !== DIAG) begin errors++; $display("FAIL clean_hold got=%h want=%h", matrix_o, DIAG); end
   endtask

   task automatic test_blank_gaps;
      bit seen;
      e_cap_i = 1'b1;
      for (int r = 0; r < 8; r++) begin
         if (r == 3) begin
            step(8'h08, 8'hFF);
            scan_row(3, 8'h08, 2, 2);
         end else begin
            scan_row(r, 8'h01 << r, 3, 2);
         end
      end
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL gaps_done got=%b want=1", seen); end
      checks++; if (matrix_o !== DIAG) begin errors++; $display("FAIL gaps_matrix got=%h want=%h", matrix_o, DIAG); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL gaps_err got=%b want=0", err_o); end
      e_cap_i = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
   endtask

   task automatic test_out_of_order;
      bit seen;
      e_cap_i = 1'b1;
      scan_row(0, 8'h11, 3, 0);
      scan_row(1, 8'h22, 3, 0);
      scan_row(3, 8'h44, 3, 0);
      step(8'h00, 8'h00);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ooo_err got=%b want=1", err_o); end
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL ooo_done got=%b want=0", d_cap_o); end
      for (int r = 0; r < 8; r++) scan_row(r, 8'hFF, 3, 0);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ooo_resync_done got=%b want=1", seen); end
      checks++; if (matrix_o !== ONES) begin errors++; $display("FAIL ooo_matrix got=%h want=%h", matrix_o, ONES); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ooo_err_sticky got=%b want=1", err_o); end
      e_cap_i = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ooo_err_idle got=%b want=1", err_o); end
      e_cap_i = 1'b1;
      step(8'h00, 8'h00);
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ooo_err_clear got=%b want=0", err_o); end
   endtask

   task automatic test_illegal;
      bit seen;
      step(8'h01, 8'h0F);
      step(8'h03, 8'h0F);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", err_o); end
      checks++; if (matrix_o !== ONES) begin errors++; $display("FAIL illegal_matrix got=%h want=%h", matrix_o, ONES); end
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL illegal_done got=%b want=0", d_cap_o); end
      for (int r = 0; r < 8; r++) scan_row(r, 8'hA5, 3, 0);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL illegal_resync_done got=%b want=1", seen); end
      checks++; if (matrix_o !== PAT_A5) begin errors++; $display("FAIL illegal_resync_matrix got=%h want=%h", matrix_o, PAT_A5); end
   endtask

   task automatic test_abort;
      bit seen;
      e_cap_i = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      e_cap_i = 1'b1;
      for (int r = 0; r < 5; r++) scan_row(r, 8'h3C, 3, 0);
      step(8'h20, 8'h3C);
      e_cap_i = 1'b0;
      step(8'h20, 8'h3C);
      step(8'h20, 8'h3C);
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", d_cap_o); end
      checks++; if (matrix_o !== PAT_A5) begin errors++; $display("FAIL abort_matrix got=%h want=%h", matrix_o, PAT_A5); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL abort_err got=%b want=0", err_o); end
      e_cap_i = 1'b1;
      for (int r = 0; r < 8; r++) scan_row(r, 8'(r), 3, 0);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_reenable_done got=%b want=1", seen); end
      checks++; if (matrix_o !== PAT_IDX) begin errors++; $display("FAIL abort_reenable_matrix got=%h want=%h", matrix_o, PAT_IDX); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL abort_reenable_err got=%b want=0", err_o); end
   endtask

   task automatic test_async_reset;
      #2;
      rst_i = 1'b1;
      #1;
      checks++; if (matrix_o !== 64'h0) begin errors++; $display("FAIL async_rst_matrix got=%h want=%h", matrix_o, 64'h0); end
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL async_rst_done got=%b want=0", d_cap_o); end
      #1;
      rst_i = 1'b0;
      e_cap_i = 1'b0;
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);
      checks++; if (d_cap_o !== 1'b0) begin errors++; $display("FAIL async_rst_idle got=%b want=0", d_cap_o); end
   endtask

   initial begin
      test_reset;
      test_clean_frame;
      test_blank_gaps;
      test_out_of_order;
      test_illegal;
      test_abort;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
